// File: rtl/mcb_burst_reader_if.sv
// Request, output stream and MCB user-port signals of the burst reader.
// slave = reader side, master = requester/consumer/MCB side.
interface mcb_burst_reader_if;
  logic        req_valid;
  logic        req_ready;
  logic [29:0] req_addr;
  logic [6:0]  req_words;

  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_data;
  logic        out_last;

  logic        p_cmd_en;
  logic [2:0]  p_cmd_instr;
  logic [5:0]  p_cmd_bl;
  logic [29:0] p_cmd_byte_addr;
  logic        p_cmd_full;

  logic        p_rd_en;
  logic [63:0] p_rd_data;
  logic        p_rd_empty;

  modport slave (
    input  req_valid, req_addr, req_words, out_ready, p_cmd_full, p_rd_data, p_rd_empty,
    output req_ready, out_valid, out_data, out_last,
           p_cmd_en, p_cmd_instr, p_cmd_bl, p_cmd_byte_addr, p_rd_en
  );

  modport master (
    output req_valid, req_addr, req_words, out_ready, p_cmd_full, p_rd_data, p_rd_empty,
    input  req_ready, out_valid, out_data, out_last,
           p_cmd_en, p_cmd_instr, p_cmd_bl, p_cmd_byte_addr, p_rd_en
  );
endinterface

// File: rtl/mcb_burst_reader.sv
// MCB read-port burst client: one read command per request, words out one cycle after pop.
// Output stream holds under backpressure; pops stall until the output register frees up.
module mcb_burst_reader #(
  parameter int TIMEOUT_CYC = 4096,
  parameter int CNT_W       = 13
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                calib_done,
  mcb_burst_reader_if.slave   bus,
  output logic                busy,
  output logic                err_len,
  output logic                err_timeout
);

  typedef enum logic [2:0] {S_WAIT_CAL, S_FLUSH, S_IDLE, S_CMD, S_DRAIN} state_e;

  state_e             state_q;
  logic               cal_meta_q, cal_sync_q;
  logic               req_ready_q, out_valid_q, out_last_q;
  logic               err_len_q, err_timeout_q;
  logic [63:0]        out_data_q;
  logic [26:0]        addr_q;
  logic [5:0]         bl_q;
  logic [6:0]         rem_q;
  logic [CNT_W-1:0]   wd_q;

  logic accept, req_legal, pop, out_hs, wd_expire;

  assign accept    = (state_q == S_IDLE) && req_ready_q && bus.req_valid;
  assign req_legal = (bus.req_words != 7'd0) && (bus.req_words <= 7'd64);
  assign out_hs    = out_valid_q && bus.out_ready;
  assign pop       = cal_sync_q && (state_q == S_DRAIN) && !bus.p_rd_empty &&
                     (rem_q != 7'd0) && (!out_valid_q || bus.out_ready);
  assign wd_expire = (state_q == S_DRAIN) && !pop && (wd_q == CNT_W'(TIMEOUT_CYC - 1));

  // cmd_en and rd_en must qualify against full/empty in the same cycle the MCB samples them
  assign bus.p_cmd_en        = cal_sync_q && (state_q == S_CMD) && !bus.p_cmd_full;
  assign bus.p_rd_en         = pop || (cal_sync_q && (state_q == S_FLUSH) && !bus.p_rd_empty);
  assign bus.p_cmd_instr     = 3'b001;
  assign bus.p_cmd_bl        = bl_q;
  assign bus.p_cmd_byte_addr = {addr_q, 3'b000};

  assign bus.req_ready = req_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_last  = out_last_q;
  assign busy          = (state_q != S_IDLE);
  assign err_len       = err_len_q;
  assign err_timeout   = err_timeout_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_WAIT_CAL;
      cal_meta_q    <= 1'b0;
      cal_sync_q    <= 1'b0;
      req_ready_q   <= 1'b0;
      out_valid_q   <= 1'b0;
      out_last_q    <= 1'b0;
      out_data_q    <= '0;
      err_len_q     <= 1'b0;
      err_timeout_q <= 1'b0;
      addr_q        <= '0;
      bl_q          <= '0;
      rem_q         <= '0;
      wd_q          <= '0;
    end else begin
      cal_meta_q <= calib_done;
      cal_sync_q <= cal_meta_q;
      err_len_q  <= 1'b0;

      if (!cal_sync_q) begin
        // loss of calibration abandons whatever burst was in flight
        state_q     <= S_WAIT_CAL;
        req_ready_q <= 1'b0;
        out_valid_q <= 1'b0;
        out_last_q  <= 1'b0;
        rem_q       <= '0;
        wd_q        <= '0;
      end else begin
        case (state_q)
          S_WAIT_CAL: state_q <= S_FLUSH;

          S_FLUSH: begin
            if (bus.p_rd_empty) begin
              state_q     <= S_IDLE;
              req_ready_q <= 1'b1;
            end
          end

          S_IDLE: begin
            if (accept) begin
              if (req_legal) begin
                addr_q      <= bus.req_addr[29:3];
                bl_q        <= 6'(bus.req_words - 7'd1);
                rem_q       <= bus.req_words;
                wd_q        <= '0;
                req_ready_q <= 1'b0;
                state_q     <= S_CMD;
              end else begin
                err_len_q <= 1'b1;
              end
            end
          end

          S_CMD: begin
            if (!bus.p_cmd_full) state_q <= S_DRAIN;
          end

          S_DRAIN: begin
            if (pop) begin
              out_data_q  <= bus.p_rd_data;
              out_valid_q <= 1'b1;
              out_last_q  <= (rem_q == 7'd1);
              rem_q       <= rem_q - 7'd1;
              wd_q        <= '0;
            end else if (out_hs && out_last_q) begin
              out_valid_q <= 1'b0;
              out_last_q  <= 1'b0;
              req_ready_q <= 1'b1;
              state_q     <= S_IDLE;
            end else if (wd_expire) begin
              err_timeout_q <= 1'b1;
              out_valid_q   <= 1'b0;
              out_last_q    <= 1'b0;
              rem_q         <= '0;
              wd_q          <= '0;
              state_q       <= S_FLUSH;
            end else begin
              if (out_hs) begin
                out_valid_q <= 1'b0;
                out_last_q  <= 1'b0;
              end
              wd_q <= wd_q + 1'b1;
            end
          end

          default: state_q <= S_WAIT_CAL;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mcb_burst_reader.sv
// Directed bench: request table plus hand-written sequences for full, timeout, calib loss and reset.
module tb_mcb_burst_reader;
  logic clk = 1'b0;
  logic reset, calib_done;
  logic busy, err_len, err_timeout;

  mcb_burst_reader_if bus();

  mcb_burst_reader #(.TIMEOUT_CYC(4096), .CNT_W(13)) dut (
    .clk(clk), .reset(reset), .calib_done(calib_done), .bus(bus),
    .busy(busy), .err_len(err_len), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  // MCB read FIFO model (first-word fall-through)
  logic [63:0] mem [0:255];
  int rd_ptr = 0;
  int wr_ptr = 0;
  assign bus.p_rd_empty = (rd_ptr == wr_ptr);
  assign bus.p_rd_data  = mem[rd_ptr[7:0]];
  always @(posedge clk) if (bus.p_rd_en && !bus.p_rd_empty) rd_ptr <= rd_ptr + 1;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // monitor state
  int          cyc = 0;
  int          n_got = 0;
  logic [63:0] got_data [0:127];
  logic        got_last [0:127];
  int          got_cyc  [0:127];
  int          n_cmd = 0;
  logic [5:0]  cmd_bl;
  logic [29:0] cmd_addr;
  logic [2:0]  cmd_instr;
  int          n_errlen = 0;
  int          last_pop_cyc = -1;
  int          to_cyc = -1;
  bit          hold_chk = 0;
  bit          hold_q = 0;
  logic [63:0] hold_dat = '0;

  initial forever begin
    @(negedge clk);
    #1;
    cyc++;
    if (hold_chk && hold_q) begin
      check("hold_valid", 64'(bus.out_valid), 64'd1);
      check("hold_data", bus.out_data, hold_dat);
    end
    hold_q   = bus.out_valid && !bus.out_ready;
    hold_dat = bus.out_data;
    if (bus.out_valid && bus.out_ready && n_got < 128) begin
      got_data[n_got] = bus.out_data;
      got_last[n_got] = bus.out_last;
      got_cyc[n_got]  = cyc;
      n_got++;
    end
    if (bus.p_cmd_en) begin
      n_cmd++;
      cmd_bl    = bus.p_cmd_bl;
      cmd_addr  = bus.p_cmd_byte_addr;
      cmd_instr = bus.p_cmd_instr;
    end
    if (err_len) n_errlen++;
    if (bus.p_rd_en && !bus.p_rd_empty && !err_timeout) last_pop_cyc = cyc;
    if (err_timeout && to_cyc < 0) to_cyc = cyc;
  end

  task automatic push(input int n, input logic [63:0] base);
    for (int i = 0; i < n; i++) begin
      mem[wr_ptr[7:0]] = base + 64'(i);
      wr_ptr++;
    end
  endtask

  task automatic clear_mon();
    n_got = 0; n_cmd = 0; n_errlen = 0; hold_q = 0;
  endtask

  task automatic wait_ready(input int budget);
    int t = 0;
    while (!bus.req_ready && t < budget) begin
      @(negedge clk); #2; t++;
    end
    check("req_ready_wait", 64'(bus.req_ready), 64'd1);
  endtask

  task automatic send_req(input logic [29:0] addr, input logic [6:0] words);
    wait_ready(60);
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_addr = addr; bus.req_words = words;
    @(negedge clk);
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_burst(input int words, input bit toggle, input int budget);
    int t = 0;
    while (n_got < words && t < budget) begin
      @(negedge clk);
      bus.out_ready = toggle ? ~bus.out_ready : 1'b1;
      #2; t++;
    end
    check("burst_complete", 64'(n_got), 64'(words));
  endtask

  typedef struct {
    logic [29:0] addr;
    logic [6:0]  words;
    bit          toggle;
    logic [5:0]  exp_bl;
    logic [29:0] exp_addr;
    bit          exp_err;
  } vec_t;

  vec_t vt [6];

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    vt[0] = '{30'h10,       7'd6,  1'b0, 6'd5,  30'h10,       1'b0};
    vt[1] = '{30'h1F,       7'd64, 1'b0, 6'd63, 30'h18,       1'b0};
    vt[2] = '{30'h2A,       7'd8,  1'b1, 6'd7,  30'h28,       1'b0};
    vt[3] = '{30'h3FFFFFFF, 7'd1,  1'b0, 6'd0,  30'h3FFFFFF8, 1'b0};
    vt[4] = '{30'h0,        7'd0,  1'b0, 6'd0,  30'h0,        1'b1};
    vt[5] = '{30'h0,        7'd65, 1'b0, 6'd0,  30'h0,        1'b1};

    reset = 1'b1; calib_done = 1'b0;
    bus.req_valid = 1'b0; bus.req_addr = '0; bus.req_words = '0;
    bus.out_ready = 1'b1; bus.p_cmd_full = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    check("rst_req_ready", 64'(bus.req_ready), 64'd0);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_out_last",  64'(bus.out_last), 64'd0);
    check("rst_out_data",  bus.out_data, 64'd0);
    check("rst_busy",      64'(busy), 64'd1);
    check("rst_cmd_en",    64'(bus.p_cmd_en), 64'd0);
    check("rst_rd_en",     64'(bus.p_rd_en), 64'd0);
    check("rst_err_len",   64'(err_len), 64'd0);
    check("rst_err_to",    64'(err_timeout), 64'd0);

    // stale words before calibration must be flushed only once calibrated
    push(3, 64'hDEAD_0000);
    @(negedge clk); reset = 1'b0;
    repeat (6) @(negedge clk);
    #2;
    check("precal_busy", 64'(busy), 64'd1);
    check("precal_no_pop", 64'(rd_ptr), 64'd0);
    @(negedge clk); calib_done = 1'b1;
    wait_ready(30);
    check("cal_flushed", 64'(wr_ptr - rd_ptr), 64'd0);

    for (int v = 0; v < 6; v++) begin
      clear_mon();
      hold_chk = 1;
      bus.out_ready = 1'b1;
      if (!vt[v].exp_err) push(int'(vt[v].words), (64'(v) << 32) + 64'd1);
      send_req(vt[v].addr, vt[v].words);
      if (vt[v].exp_err) begin
        repeat (4) @(negedge clk);
        #2;
        check("illegal_err_len", 64'(n_errlen), 64'd1);
        check("illegal_no_cmd",  64'(n_cmd), 64'd0);
        check("illegal_idle",    64'(busy), 64'd0);
        check("illegal_ready",   64'(bus.req_ready), 64'd1);
        check("illegal_no_data", 64'(n_got), 64'd0);
      end else begin
        wait_burst(int'(vt[v].words), vt[v].toggle, 400);
        @(negedge clk);
        #2;
        check("idle_after_last", 64'(busy), 64'd0);
        check("ready_after_last", 64'(bus.req_ready), 64'd1);
        check("cmd_count", 64'(n_cmd), 64'd1);
        check("cmd_bl",    64'(cmd_bl), 64'(vt[v].exp_bl));
        check("cmd_addr",  64'(cmd_addr), 64'(vt[v].exp_addr));
        check("cmd_instr", 64'(cmd_instr), 64'd1);
        check("fifo_drained", 64'(wr_ptr - rd_ptr), 64'd0);
        for (int i = 0; i < n_got; i++) begin
          check("word_data", got_data[i], (64'(v) << 32) + 64'(i + 1));
          check("word_last", 64'(got_last[i]), 64'(i == int'(vt[v].words) - 1));
        end
        if (!vt[v].toggle && n_got == int'(vt[v].words))
          check("back_to_back", 64'(got_cyc[n_got-1] - got_cyc[0]), 64'(n_got - 1));
      end
    end
    hold_chk = 0;

    // command FIFO full holds off cmd_en
    clear_mon();
    push(2, 64'hC0DE_0000);
    bus.p_cmd_full = 1'b1;
    send_req(30'h40, 7'd2);
    repeat (10) @(negedge clk);
    #2;
    check("full_no_cmd", 64'(n_cmd), 64'd0);
    check("full_busy",   64'(busy), 64'd1);
    @(negedge clk); bus.p_cmd_full = 1'b0;
    wait_burst(2, 1'b0, 50);
    check("full_one_cmd", 64'(n_cmd), 64'd1);
    check("full_word1", got_data[1], 64'hC0DE_0001);

    // never pop beyond the request
    clear_mon();
    push(5, 64'hE0);
    send_req(30'h80, 7'd3);
    wait_burst(3, 1'b0, 50);
    repeat (3) @(negedge clk);
    #2;
    check("leftover_words", 64'(wr_ptr - rd_ptr), 64'd2);

    // 4-word burst with only the 2 leftover words available
    clear_mon();
    to_cyc = -1; last_pop_cyc = -1;
    send_req(30'hC0, 7'd4);
    for (int t = 0; t < 5000 && to_cyc < 0; t++) @(negedge clk);
    #2;
    check("to_fired",      64'(to_cyc >= 0), 64'd1);
    check("to_words",      64'(n_got), 64'd2);
    check("to_word0",      got_data[0], 64'hE3);
    check("to_interval",   64'(to_cyc - last_pop_cyc), 64'd4097);
    check("to_out_valid",  64'(bus.out_valid), 64'd0);
    wait_ready(50);
    check("to_idle",       64'(busy), 64'd0);
    check("to_sticky",     64'(err_timeout), 64'd1);

    // calibration loss mid-burst
    clear_mon();
    push(3, 64'hF0);
    bus.out_ready = 1'b0;
    send_req(30'h100, 7'd8);
    repeat (5) @(negedge clk);
    #2;
    check("cal_pre_valid", 64'(bus.out_valid), 64'd1);
    @(negedge clk); calib_done = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    check("cal_drop_valid", 64'(bus.out_valid), 64'd0);
    check("cal_drop_busy",  64'(busy), 64'd1);
    check("cal_drop_ready", 64'(bus.req_ready), 64'd0);
    @(negedge clk); calib_done = 1'b1;
    wait_ready(40);
    check("cal_reflush", 64'(wr_ptr - rd_ptr), 64'd0);

    // reset mid-burst
    clear_mon();
    push(3, 64'hA0);
    send_req(30'h140, 7'd8);
    repeat (5) @(negedge clk);
    #2;
    check("rst_pre_valid", 64'(bus.out_valid), 64'd1);
    @(negedge clk); reset = 1'b1;
    @(negedge clk);
    #2;
    check("mid_rst_valid", 64'(bus.out_valid), 64'd0);
    check("mid_rst_data",  bus.out_data, 64'd0);
    check("mid_rst_ready", 64'(bus.req_ready), 64'd0);
    check("mid_rst_busy",  64'(busy), 64'd1);
    check("mid_rst_err",   64'(err_timeout), 64'd0);
    check("mid_rst_rd_en", 64'(bus.p_rd_en), 64'd0);
    @(negedge clk); reset = 1'b0;
    wait_ready(40);
    check("rst_reflush", 64'(wr_ptr - rd_ptr), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
